// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and synchronous flush.
// Define FIFO_FWFT_EN to get first-word fall-through reads instead of registered 1-cycle reads.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          wr_ack,
  output logic                          overflow,
  output logic                          underflow,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  wr_ok;
  logic                  rd_ok;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  assign wr_ok = wr_en & ~full  & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      wr_ack    <= wr_ok;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  // Storage is deliberately left unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr];
`else
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     data_q <= '0;
    else if (rd_ok) data_q <= mem[rd_ptr];
  end

  assign data_out = data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: vector table plus scoreboard queue for read data,
// with hand-written sequences for flush, mid-operation reset and a DEPTH=6 instance.
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_out;
  logic        full, empty, almost_full, almost_empty;
  logic        wr_ack, overflow, underflow;
  logic [3:0]  count;

  logic        flush6;
  logic [15:0] data_in6;
  logic        wr_en6;
  logic        rd_en6;
  logic [15:0] data_out6;
  logic        full6, empty6, almost_full6, almost_empty6;
  logic        wr_ack6, overflow6, underflow6;
  logic [2:0]  count6;

  int nChecks = 0;
  int nPass   = 0;

  logic [15:0] sb[$];
  logic [15:0] lastData;
  int          mcount;

  typedef struct {
    bit          f;
    bit          w;
    bit          r;
    logic [15:0] d;
    int          cnt;
    bit          ack;
    bit          ovf;
    bit          udf;
  } vec_t;

  vec_t vecs[19];

  sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(data_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow), .count(count)
  );

  sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .flush(flush6), .data_in(data_in6),
    .wr_en(wr_en6), .rd_en(rd_en6), .data_out(data_out6),
    .full(full6), .empty(empty6), .almost_full(almost_full6), .almost_empty(almost_empty6),
    .wr_ack(wr_ack6), .overflow(overflow6), .underflow(underflow6), .count(count6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drives one cycle on the 8-deep FIFO and keeps the scoreboard in step with it.
  task automatic applyStimulus(input bit f, input bit w, input bit r, input logic [15:0] d);
    bit wrOk, rdOk;
    logic [15:0] popped;
    @(negedge clk);
    flush = f; wr_en = w; rd_en = r; data_in = d;
    wrOk = w && !f && (mcount < 8);
    rdOk = r && !f && (mcount > 0);
    @(posedge clk);
    #1;
    if (f) sb.delete();
    if (rdOk) begin
      popped = sb.pop_front();
`ifndef FIFO_FWFT_EN
      lastData = popped;
`endif
    end
    if (wrOk) sb.push_back(d);
    if (f) mcount = 0;
    else mcount = mcount + int'(wrOk) - int'(rdOk);
  endtask

  task automatic checkOutput(input string name, input int expCount,
                             input bit expAck, input bit expOvf, input bit expUdf);
    logic [15:0] expData;
`ifdef FIFO_FWFT_EN
    expData = (sb.size() > 0) ? sb[0] : 16'h0;
`else
    expData = lastData;
`endif
    chk({name, ".count"}, 32'(count), 32'(expCount));
    chk({name, ".full"}, 32'(full), 32'(expCount == 8));
    chk({name, ".empty"}, 32'(empty), 32'(expCount == 0));
    chk({name, ".almost_full"}, 32'(almost_full), 32'(expCount >= 7));
    chk({name, ".almost_empty"}, 32'(almost_empty), 32'(expCount <= 1));
    chk({name, ".wr_ack"}, 32'(wr_ack), 32'(expAck));
    chk({name, ".overflow"}, 32'(overflow), 32'(expOvf));
    chk({name, ".underflow"}, 32'(underflow), 32'(expUdf));
    chk({name, ".data_out"}, 32'(data_out), 32'(expData));
  endtask

  task automatic cyc6(input bit w, input bit r, input logic [15:0] d);
    @(negedge clk);
    wr_en6 = w; rd_en6 = r; data_in6 = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fill: idle, 8 writes, overflow write, 8 reads, underflow read.
    vecs[0] = '{f:0, w:0, r:0, d:16'h0, cnt:0, ack:0, ovf:0, udf:0};
    for (int i = 1; i <= 8; i++)
      vecs[i] = '{f:0, w:1, r:0, d:16'(i), cnt:i, ack:1, ovf:0, udf:0};
    vecs[9] = '{f:0, w:1, r:0, d:16'h9, cnt:8, ack:0, ovf:1, udf:0};
    for (int i = 0; i < 8; i++)
      vecs[10+i] = '{f:0, w:0, r:1, d:16'h0, cnt:7-i, ack:0, ovf:0, udf:0};
    vecs[18] = '{f:0, w:0, r:1, d:16'h0, cnt:0, ack:0, ovf:0, udf:1};

    rst_n = 1'b0; flush = 0; wr_en = 0; rd_en = 0; data_in = '0;
    flush6 = 0; wr_en6 = 0; rd_en6 = 0; data_in6 = '0;
    lastData = '0; mcount = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset", 0, 0, 0, 0);

    for (int i = 0; i < 19; i++)
      begin
        applyStimulus(vecs[i].f, vecs[i].w, vecs[i].r, vecs[i].d);
        checkOutput($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ack, vecs[i].ovf, vecs[i].udf);
      end

    // Streaming through pointer wrap at constant occupancy of one.
    applyStimulus(0, 1, 0, 16'h0100);
    checkOutput("stream_first", 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 1, 16'h0101 + 16'(i));
      checkOutput($sformatf("stream%0d", i), 1, 1, 0, 0);
    end
    applyStimulus(0, 0, 1, 16'h0);
    checkOutput("stream_drain", 0, 0, 0, 0);

    // Flush with both requests high beats the requests and keeps data_out.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 16'h0200 + 16'(i));
      checkOutput($sformatf("prefill%0d", i), i + 1, 1, 0, 0);
    end
    applyStimulus(1, 1, 1, 16'h02FF);
    checkOutput("flush", 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 16'h0300);
    checkOutput("post_flush_wr", 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 16'h0);
    checkOutput("post_flush_rd", 0, 0, 0, 0);

    // Asynchronous reset in the middle of traffic.
    applyStimulus(0, 1, 0, 16'h0400);
    applyStimulus(0, 1, 0, 16'h0401);
    checkOutput("pre_reset", 2, 1, 0, 0);
    @(negedge clk);
    wr_en = 1; data_in = 16'h0402;
    #2 rst_n = 1'b0;
    #1;
    sb.delete(); mcount = 0; lastData = '0;
    checkOutput("async_reset", 0, 0, 0, 0);
    wr_en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 1, 16'h0);
    checkOutput("after_reset_rd", 0, 0, 0, 1);

    // DEPTH=6 instance: full-state simultaneous request, then wrap past entry 5.
    for (int i = 1; i <= 6; i++) begin
      cyc6(1, 0, 16'(i));
      chk($sformatf("d6.count_w%0d", i), 32'(count6), 32'(i));
`ifdef FIFO_FWFT_EN
      if (i == 1) chk("d6.fwft_first", 32'(data_out6), 32'h1);
`else
      if (i == 1) chk("d6.no_fall_through", 32'(data_out6), 32'h0);
`endif
    end
    chk("d6.full", 32'(full6), 32'h1);
    chk("d6.almost_full", 32'(almost_full6), 32'h1);
    cyc6(1, 1, 16'h7);
    chk("d6.overflow", 32'(overflow6), 32'h1);
    chk("d6.wr_ack", 32'(wr_ack6), 32'h0);
    chk("d6.count_rw", 32'(count6), 32'h5);
`ifdef FIFO_FWFT_EN
    chk("d6.data_rw", 32'(data_out6), 32'h2);
`else
    chk("d6.data_rw", 32'(data_out6), 32'h1);
`endif
    for (int k = 0; k < 5; k++) begin
      cyc6(0, 1, 16'h0);
      chk($sformatf("d6.count_r%0d", k), 32'(count6), 32'(4 - k));
`ifdef FIFO_FWFT_EN
      chk($sformatf("d6.data_r%0d", k), 32'(data_out6), (k < 4) ? 32'(k + 3) : 32'h0);
`else
      chk($sformatf("d6.data_r%0d", k), 32'(data_out6), 32'(k + 2));
`endif
    end
    cyc6(1, 0, 16'h0010);
    cyc6(1, 0, 16'h0011);
    cyc6(0, 1, 16'h0);
`ifdef FIFO_FWFT_EN
    chk("d6.wrap_r0", 32'(data_out6), 32'h11);
`else
    chk("d6.wrap_r0", 32'(data_out6), 32'h10);
`endif
    cyc6(0, 1, 16'h0);
`ifdef FIFO_FWFT_EN
    chk("d6.wrap_r1", 32'(data_out6), 32'h0);
`else
    chk("d6.wrap_r1", 32'(data_out6), 32'h11);
`endif
    chk("d6.empty", 32'(empty6), 32'h1);
    cyc6(0, 0, 16'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.
- Generalised in data width, depth (power of two not required) and almost-full/almost-empty thresholds.
- Adds an occupancy count output and a synchronous flush.
- Drop-in storage element between a producer and consumer on one clock domain; the existing transaction-based bench drives it.

Parameters:
- DATA_WIDTH, 16, bits per entry (>=1)
- DEPTH, 8, number of entries (>=2, any integer)
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of contents
- data_in  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- wr_ack  out  1  previous-cycle write accepted
- overflow  out  1  previous-cycle write rejected (full)
- underflow  out  1  previous-cycle read rejected (empty)
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n=0, async assert, sync-to-clk release):
  - wr_ptr=rd_ptr=count=0.
  - data_out=0; wr_ack=overflow=underflow=0.
  - Outputs: empty=1, full=0, almost_empty=1 (AE_LEVEL>=0), almost_full=0.
  - Memory contents need not be cleared.
- Accepted write: wr_en=1 and not full, or wr_en=1 and full with a write not blocked by the rule below. The write stores mem[wr_ptr], advances wr_ptr, and sets wr_ack=1 next cycle.
- Accepted read: rd_en=1 and not empty. It loads data_out<=mem[rd_ptr] (1-cycle read latency) and advances rd_ptr. data_out holds its value when no read is accepted.
- Pointers wrap from DEPTH-1 to 0; non-power-of-two DEPTH wraps explicitly, not by bit truncation.
- Simultaneous wr_en & rd_en:
  - not empty and not full: both accepted; count unchanged.
  - full: read only; write rejected, overflow=1 next cycle.
  - empty: write only; read rejected, underflow=1 next cycle.
- count: +1 on write only, -1 on read only, unchanged otherwise.
- full, empty, almost_full, almost_empty: combinational from count.
- wr_ack, overflow, underflow: registered, single-cycle pulses reflecting the previous edge's request. Each is 0 when the corresponding request is absent.
- flush=1 at a clock edge:
  - wr_ptr=rd_ptr=count=0.
  - wr_en/rd_en ignored that edge; wr_ack=overflow=underflow=0 next cycle.
  - data_out holds.
  - flush has priority over all requests; reset has priority over flush.
- Reset asserted mid-operation: immediate return to reset state; no partial write is visible after release.
- No combinational path from data_in to data_out (non-FWFT).

Optional Feature:
- Macro FIFO_FWFT_EN selects first-word fall-through.
- Defined:
  - data_out = mem[rd_ptr] combinationally whenever empty=0, and 0 when empty.
  - An accepted rd_en pops the head; the next entry appears in the same cycle after the edge.
  - Flags, count, wr_ack, overflow and underflow are unchanged from the default mode.
- Undefined: registered 1-cycle read latency as above.

Test Plan (DEPTH=8, DATA_WIDTH=16, AF_LEVEL=7, AE_LEVEL=1):
- Reset then idle -> empty=1, almost_empty=1, full=0, count=0, data_out=0, all pulses 0.
- Write 0x0001..0x0008 on 8 cycles -> wr_ack=1 each following cycle; almost_full=1 at count=7; full=1 at count=8. A 9th write (0x0009) gives overflow=1 and count stays 8.
- Read 8 times -> data_out 0x0001..0x0008 in order, 1 cycle after each rd_en. A 9th read gives underflow=1, data_out holds 0x0008, empty=1.
- Write/read 20 values continuously with both enables high after the first write -> count constant at 1, data order preserved across pointer wrap.
- Fill to count=5, then flush with wr_en=rd_en=1 -> count=0, empty=1, no wr_ack/underflow, data_out unchanged.
- With DEPTH=6, write 6 and assert rd_en&wr_en while full -> read returns first entry, overflow=1, count=5. With FIFO_FWFT_EN, data_out=0x0001 the cycle after the first write.
